// File: rtl/dual_diagonal_backsub_lanes.sv
// dual_diagonal_backsub_lanes: LANES-wide XOR chain (accumulate or differential) with block framing and a single registered output stage.
// Ports: i_clock/i_reset (sync, active-low); i_mode, i_num_beats latched on a block's first beat;
// i_in_data/i_in_valid/i_in_last/o_in_ready input handshake; o_out_data/o_out_valid/o_out_last/o_len_err/i_out_ready
// output handshake; o_cfg_err pulses with the first output beat of a block whose length was clamped.
module dual_diagonal_backsub_lanes #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 2,
  parameter int MAX_BEATS = 1024,
  parameter int LEN_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_mode,
  input  logic [LEN_W-1:0]       i_num_beats,
  input  logic [LANES*WIDTH-1:0] i_in_data,
  input  logic                   i_in_valid,
  input  logic                   i_in_last,
  output logic                   o_in_ready,
  output logic [LANES*WIDTH-1:0] o_out_data,
  output logic                   o_out_valid,
  output logic                   o_out_last,
  output logic                   o_len_err,
  output logic                   o_cfg_err,
  input  logic                   i_out_ready
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                 r_state;
  logic                   r_mode;
  logic [LEN_W-1:0]       r_len, r_cnt;
  logic [WIDTH-1:0]       r_chain;
  logic                   w_accept, w_first, w_clamp, w_mode, w_at_end, w_end;
  logic [LEN_W-1:0]       w_len, w_cnt;
  logic [WIDTH-1:0]       w_chain, w_prev;
  logic [LANES*WIDTH-1:0] w_y;
  assign o_in_ready = !o_out_valid | i_out_ready;
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_first    = r_state == IDLE;
  assign w_clamp    = i_num_beats == '0 || i_num_beats > LEN_W'(MAX_BEATS);
  // In IDLE the current beat opens a block, so config comes straight from the inputs and the chain starts at zero.
  assign w_len      = w_first ? (w_clamp ? LEN_W'(MAX_BEATS) : i_num_beats) : r_len;
  assign w_mode     = w_first ? i_mode : r_mode;
  assign w_cnt      = w_first ? '0 : r_cnt;
  assign w_chain    = w_first ? '0 : r_chain;
  assign w_at_end   = w_cnt == w_len - LEN_W'(1);
  assign w_end      = w_at_end | i_in_last;
  // w_prev carries the lane-to-lane link: previous output (accumulate) or previous input (differential).
  always_comb begin
    w_y    = '0;
    w_prev = w_chain;
    for (int n = 0; n < LANES; n++) begin
      w_y[n*WIDTH +: WIDTH] = i_in_data[n*WIDTH +: WIDTH] ^ w_prev;
      w_prev = w_mode ? w_y[n*WIDTH +: WIDTH] : i_in_data[n*WIDTH +: WIDTH];
    end
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_mode      <= 1'b0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_chain     <= '0;
      o_out_data  <= '0;
      o_out_valid <= 1'b0;
      o_out_last  <= 1'b0;
      o_len_err   <= 1'b0;
      o_cfg_err   <= 1'b0;
    end else begin
      o_cfg_err <= w_accept & w_first & w_clamp;
      if (w_accept) begin
        o_out_valid <= 1'b1;
        o_out_data  <= w_y;
        o_out_last  <= w_end;
        o_len_err   <= w_at_end ^ i_in_last;
        r_mode      <= w_mode;
        r_len       <= w_len;
        r_state     <= w_end ? IDLE : RUN;
        r_cnt       <= w_end ? '0 : w_cnt + LEN_W'(1);
        r_chain     <= w_end ? '0 : w_prev;
      end else if (i_out_ready) begin
        o_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dual_diagonal_backsub_lanes.sv
// tb_dual_diagonal_backsub_lanes: scoreboard bench for dual_diagonal_backsub_lanes (WIDTH=8, LANES=2).
module tb_dual_diagonal_backsub_lanes;
  typedef struct {
    logic [15:0] d;
    logic        l;
    logic        e;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_mode;
  logic [10:0] i_num_beats;
  logic [15:0] i_in_data;
  logic        i_in_valid, i_in_last, o_in_ready;
  logic [15:0] o_out_data;
  logic        o_out_valid, o_out_last, o_len_err, o_cfg_err, i_out_ready;
  exp_t        q[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  logic        m_idle = 1'b1;
  logic        m_mode;
  int          m_len, m_cnt;
  logic [7:0]  m_acc, m_px;
  dual_diagonal_backsub_lanes #(.WIDTH(8), .LANES(2), .MAX_BEATS(1024)) u_dut (
    .i_clock(clk), .i_reset(rst), .i_mode(i_mode), .i_num_beats(i_num_beats),
    .i_in_data(i_in_data), .i_in_valid(i_in_valid), .i_in_last(i_in_last), .o_in_ready(o_in_ready),
    .o_out_data(o_out_data), .o_out_valid(o_out_valid), .o_out_last(o_out_last),
    .o_len_err(o_len_err), .o_cfg_err(o_cfg_err), .i_out_ready(i_out_ready)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst && o_out_valid && i_out_ready) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_out got d=%h l=%b e=%b expected no beat", o_out_data, o_out_last, o_len_err);
      end else begin
        mon_e = q.pop_front();
        if ({o_out_data, o_out_last, o_len_err} !== {mon_e.d, mon_e.l, mon_e.e}) begin
          miscompares++;
          $display("FAIL out_beat got d=%h l=%b e=%b expected d=%h l=%b e=%b",
                   o_out_data, o_out_last, o_len_err, mon_e.d, mon_e.l, mon_e.e);
        end
      end
    end
  end
  task automatic send_beat(input logic [15:0] x, input logic last);
    int n;
    logic first, clamp;
    logic [7:0] w, y;
    exp_t e;
    i_in_data  = x;
    i_in_last  = last;
    i_in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (!o_in_ready) begin
      miscompares++;
      $display("FAIL in_ready_timeout got=0 expected=1");
      i_in_valid = 1'b0;
      return;
    end
    first = m_idle;
    clamp = i_num_beats == 0 || i_num_beats > 1024;
    if (first) begin
      m_mode = i_mode;
      m_len  = clamp ? 1024 : int'(i_num_beats);
      m_cnt  = 0;
      m_acc  = 8'h00;
      m_px   = 8'h00;
    end
    for (int k = 0; k < 2; k++) begin
      w = x[k*8 +: 8];
      y = m_mode ? (m_acc ^ w) : (m_px ^ w);
      m_acc = y;
      m_px  = w;
      e.d[k*8 +: 8] = y;
    end
    e.l = (m_cnt == m_len - 1) || last;
    e.e = (m_cnt == m_len - 1) != last;
    q.push_back(e);
    m_idle = e.l;
    if (!e.l) m_cnt++;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
    vectors++;
    if (o_cfg_err !== (first && clamp)) begin
      miscompares++;
      $display("FAIL cfg_err got=%b expected=%b", o_cfg_err, first && clamp);
    end
  endtask
  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d pending expected=0", q.size());
      q.delete();
    end
  endtask
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({o_out_valid, o_out_last, o_len_err, o_cfg_err, o_out_data, o_in_ready} !== {4'b0, 16'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset got v=%b l=%b e=%b c=%b d=%h r=%b expected zeros, ready=1",
               o_out_valid, o_out_last, o_len_err, o_cfg_err, o_out_data, o_in_ready);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_accumulate();
    i_mode = 1'b1;
    i_num_beats = 11'd2;
    send_beat(16'h0201, 1'b0);
    send_beat(16'h0804, 1'b1);
    wait_drain();
  endtask
  task automatic test_differential();
    i_mode = 1'b0;
    i_num_beats = 11'd2;
    send_beat(16'h0201, 1'b0);
    i_mode = 1'b1;
    i_num_beats = 11'd7;
    send_beat(16'h0804, 1'b1);
    wait_drain();
  endtask
  task automatic test_back_to_back();
    i_mode = 1'b1;
    i_num_beats = 11'd1;
    send_beat(16'h0201, 1'b1);
    send_beat(16'h0804, 1'b1);
    i_num_beats = 11'd3;
    for (int b = 0; b < 4; b++) begin
      i_mode = b[0];
      for (int j = 0; j < 3; j++) send_beat(16'($urandom), j == 2);
    end
    wait_drain();
  endtask
  task automatic test_backpressure();
    logic [15:0] held;
    i_mode = 1'b1;
    i_num_beats = 11'd5;
    send_beat(16'h1122, 1'b0);
    send_beat(16'h4488, 1'b0);
    i_out_ready = 1'b0;
    held = o_out_data;
    i_in_data = 16'hA55A;
    i_in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (o_in_ready !== 1'b0 || o_out_valid !== 1'b1 || o_out_data !== held) begin
        miscompares++;
        $display("FAIL stall got r=%b v=%b d=%h expected r=0 v=1 d=%h", o_in_ready, o_out_valid, o_out_data, held);
      end
    end
    @(posedge clk);
    #1;
    i_out_ready = 1'b1;
    send_beat(16'hA55A, 1'b0);
    send_beat(16'h0F0F, 1'b0);
    send_beat(16'h3C3C, 1'b1);
    wait_drain();
  endtask
  task automatic test_len_err();
    i_mode = 1'b1;
    i_num_beats = 11'd4;
    send_beat(16'h0201, 1'b0);
    send_beat(16'h0804, 1'b1);
    i_mode = 1'b0;
    i_num_beats = 11'd2;
    send_beat(16'h1234, 1'b0);
    send_beat(16'h5678, 1'b0);
    wait_drain();
  endtask
  task automatic test_cfg_clamp();
    i_mode = 1'b1;
    i_num_beats = 11'd0;
    for (int j = 0; j < 1024; j++) send_beat(16'($urandom), j == 1023);
    i_num_beats = 11'd2000;
    send_beat(16'h00FF, 1'b1);
    wait_drain();
  endtask
  task automatic test_reset_mid();
    i_mode = 1'b1;
    i_num_beats = 11'd4;
    send_beat(16'h7777, 1'b0);
    send_beat(16'h1111, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({o_out_valid, o_out_last, o_len_err, o_cfg_err, o_out_data} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_mid got v=%b l=%b e=%b c=%b d=%h expected zeros",
               o_out_valid, o_out_last, o_len_err, o_cfg_err, o_out_data);
    end
    q.delete();
    m_idle = 1'b1;
    rst = 1'b1;
    i_num_beats = 11'd2;
    send_beat(16'h0201, 1'b0);
    send_beat(16'h0804, 1'b1);
    wait_drain();
  endtask
  initial begin
    rst = 1'b0;
    i_mode = 1'b1;
    i_num_beats = 11'd4;
    i_in_data = 16'h0;
    i_in_valid = 1'b0;
    i_in_last = 1'b0;
    i_out_ready = 1'b1;
    test_reset();
    test_accumulate();
    test_differential();
    test_back_to_back();
    test_backpressure();
    test_len_err();
    test_cfg_clamp();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dual_diagonal_backsub_lanes.md
Name: dual_diagonal_backsub_lanes

Overview:
Parametrised successor to the single-lane dual-diagonal back-substitution stage in the LDPC encoder parity path. It processes LANES words per beat, with a chain carried across lanes and beats. It supports two runtime modes: accumulate (true back-substitution, p_k = p_(k-1) ^ x_k) and differential (y_k = x_(k-1) ^ x_k). Block length is set at runtime, the chain clears at each block boundary, and both sides use valid/ready handshakes with backpressure.

Parameters:
WIDTH, 8, bits per lane word
LANES, 2, words per beat; lane 0 is earliest in sequence order
MAX_BEATS, 1024, maximum beats per block
LEN_W, $clog2(MAX_BEATS+1), width of block-length input

Ports:
i_clock  input  1  clock, all logic on rising edge
i_reset  input  1  synchronous reset, active-low (0 = reset)
i_mode  input  1  0 = differential, 1 = accumulate; sampled on the first beat of each block
i_num_beats  input  LEN_W  block length in beats; sampled on the first beat of each block
i_in_data  input  LANES*WIDTH  lane n at bits [n*WIDTH +: WIDTH]
i_in_valid  input  1  input beat valid
i_in_last  input  1  upstream end-of-block marker
o_in_ready  output  1  input beat accepted when i_in_valid & o_in_ready
o_out_data  output  LANES*WIDTH  result lanes, same packing as input
o_out_valid  output  1  output beat valid
o_out_last  output  1  final beat of the block
o_len_err  output  1  qualified by o_out_valid; i_in_last disagreed with the beat count
o_cfg_err  output  1  one-cycle pulse; length was out of range and was clamped
i_out_ready  input  1  downstream ready

Behaviour:
- Reset (i_reset=0 at an edge): o_out_valid, o_out_last, o_len_err, o_cfg_err, o_out_data, chain state, beat counter all 0; FSM goes to IDLE. Reset mid-block discards the partial block and any pending output.
- o_in_ready = !o_out_valid | i_out_ready. This is a single registered stage, full throughput, combinational ready path only.
- Latency: one cycle from accept to o_out_valid.
- While o_out_valid & !i_out_ready: o_out_data, o_out_last and o_len_err are held stable.
- FSM IDLE: the first accepted beat latches mode and length, processes the beat, then moves to RUN. If the length is 1 or that beat's i_in_last=1, it ends the block and stays in IDLE.
- FSM RUN: each accepted beat increments the counter. The block ends when count reaches length-1 or i_in_last=1, whichever comes first; the FSM then returns to IDLE and clears chain state to 0.
- Length clamping: if i_num_beats is 0 or greater than MAX_BEATS, MAX_BEATS is used and o_cfg_err pulses in the accept cycle.
- Accumulate mode: y0 = s ^ x0, yn = y(n-1) ^ xn; next s = y(LANES-1).
- Differential mode: y0 = d ^ x0, yn = x(n-1) ^ xn; next d = x(LANES-1).
- Chain state is 0 at the start of every block.
- Lane arithmetic is bitwise XOR only, WIDTH-preserving, with no carries.
- o_out_last = 1 on the output beat that ends the block.
- o_len_err = 1 on that beat in two cases:
  - Early: i_in_last arrived before count reached length-1.
  - Missing: count reached length-1 without i_in_last.
- i_in_last=1 exactly on the length-th beat gives no error.
- Simultaneous events: a block end and the next block's first beat may be accepted on back-to-back cycles with no bubble; the new block uses cleared state.
- Inputs while o_in_ready=0 are ignored. Mode and length changes mid-block are ignored.

Test Plan:
- Accumulate, LANES=1, len 4, in 01,02,04,08, last on beat 4 -> out 01,03,07,0F; last on 4th output; o_len_err=0.
- Differential, LANES=1, len 4, same input -> out 01,03,06,0C.
- Accumulate, LANES=2, len 2, beats {x1=02,x0=01}, {08,04} -> {03,01}, {0F,07}.
- Back-to-back blocks, len 2, accumulate, in 01,02 | 04,08 -> 01,03 | 04,0C; no idle cycle; o_out_last on outputs 2 and 4.
- Backpressure: i_out_ready low for 3 cycles mid-stream -> o_in_ready=0, output held stable, no beat lost or duplicated; sequence matches the unstalled golden model.
- Errors and reset:
  - len 4 with i_in_last on beat 2 -> o_out_last and o_len_err on output 2.
  - i_num_beats=0 -> o_cfg_err pulse, length 1024.
  - i_reset=0 mid-block -> all outputs 0; next block starts from zero state.
